// File: rtl/base_crdarb_pkg.sv
// Shared constants and helpers for the base_crdarb credit-gated round-robin arbiter.
package base_crdarb_pkg;

    localparam int DEF_WAYS  = 4;
    localparam int DEF_WIDTH = 6;
    localparam int DEF_RSTV  = 16;

    // Ceiling log2 with a floor of 1 so that index ports are never zero-width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/base_incdec.sv
// Up/down credit counter: +1 on inc only, -1 on dec only, hold on both or neither.
module base_incdec #(
    parameter int width = 6,
    parameter int rstv  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [width-1:0] cnt
);

    localparam logic [width-1:0] CNT_ONE  = width'(1);
    localparam logic [width-1:0] CNT_INIT = width'(rstv);

    logic [width-1:0] cnt_r;

    // Credit count register; bounds are enforced by the caller.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= CNT_INIT;
        end else if (inc && !dec) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else if (dec && !inc) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/base_crdarb.sv
// Credit-gated round-robin arbiter with same-cycle grant and sticky overflow error.
// Optional feature: define BASE_CRDARB_PRIO0_EN to give requester 0 strict priority.
module base_crdarb
    import base_crdarb_pkg::*;
#(
    parameter int ways  = DEF_WAYS,
    parameter int width = DEF_WIDTH,
    parameter int rstv  = DEF_RSTV
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ways-1:0]          i_v,
    output logic [ways-1:0]          o_r,
    input  logic                     i_crd_rtn,
    output logic                     o_gnt_v,
    output logic [clog2(ways)-1:0]   o_gnt_id,
    output logic [width-1:0]         o_crd,
    output logic                     o_zero,
    output logic                     o_err
);

    localparam int IDW = clog2(ways);
    localparam logic [IDW-1:0]   ID_ZERO  = {IDW{1'b0}};
    localparam logic [IDW-1:0]   ID_LAST  = IDW'(ways - 1);
    localparam logic [IDW-1:0]   ID_ONE   = IDW'(1);
    localparam logic [IDW:0]     WAYS_EXT = (IDW+1)'(ways);
    localparam logic [width-1:0] CRD_MAX  = width'(rstv);
    localparam logic [width-1:0] CRD_ZERO = {width{1'b0}};
    localparam logic [ways-1:0]  ONEHOT0  = ways'(1);

    logic [IDW-1:0]   ptr_r;
    logic             err_r;
    logic [width-1:0] crd_s;
    logic             rr_found_s;
    logic [IDW-1:0]   rr_win_s;
    logic [IDW:0]     sum_s;
    logic [IDW-1:0]   cand_s;
    logic [IDW-1:0]   sel_s;
    logic             prio_s;
    logic             grant_s;
    logic             full_s;
    logic             ovf_s;
    logic             inc_s;

    // Round-robin search: first requesting index at or after ptr, wrapping.
    always_comb begin
        rr_found_s = 1'b0;
        rr_win_s   = ID_ZERO;
        sum_s      = {(IDW+1){1'b0}};
        cand_s     = ID_ZERO;
        for (int i = 0; i < ways; i++) begin
            sum_s = {1'b0, ptr_r} + (IDW+1)'(i);
            if (sum_s >= WAYS_EXT) begin
                sum_s = sum_s - WAYS_EXT;
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDW-1:0];
            if (!rr_found_s && i_v[cand_s]) begin
                rr_found_s = 1'b1;
                rr_win_s   = cand_s;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Final selection, credit gating and reset masking of the grant.
    always_comb begin
        sel_s   = rr_win_s;
        prio_s  = 1'b0;
`ifdef BASE_CRDARB_PRIO0_EN
        if (i_v[0]) begin
            sel_s  = ID_ZERO;
            prio_s = 1'b1;
        end else begin
            sel_s  = rr_win_s;
        end
`endif
        grant_s = reset && (rr_found_s || prio_s) && (crd_s != CRD_ZERO);
    end

    // A return at full credit with no simultaneous grant is an overflow and is dropped.
    assign full_s = (crd_s == CRD_MAX);
    assign ovf_s  = i_crd_rtn && full_s && !grant_s;
    assign inc_s  = i_crd_rtn && !ovf_s;

    base_incdec #(
        .width (width),
        .rstv  (rstv)
    ) u_incdec (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_s),
        .dec   (grant_s),
        .cnt   (crd_s)
    );

    // Pointer advances past a round-robin winner; priority grants leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= ID_ZERO;
        end else if (grant_s && !prio_s) begin
            ptr_r <= (sel_s == ID_LAST) ? ID_ZERO : (sel_s + ID_ONE);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (ovf_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign o_r      = grant_s ? (ONEHOT0 << sel_s) : {ways{1'b0}};
    assign o_gnt_v  = grant_s;
    assign o_gnt_id = grant_s ? sel_s : ID_ZERO;
    assign o_crd    = crd_s;
    assign o_zero   = (crd_s == CRD_ZERO);
    assign o_err    = err_r;

endmodule

// File: tb/tb_base_crdarb.sv
// Self-checking bench for base_crdarb: directed scenarios then randomized traffic
// against a reference model built from the arbitration and credit rules.
module tb_base_crdarb;

    localparam int WAYS  = 4;
    localparam int WIDTH = 6;
    localparam int RSTV  = 16;

    logic             clk;
    logic             reset;
    logic [WAYS-1:0]  i_v;
    logic [WAYS-1:0]  o_r;
    logic             i_crd_rtn;
    logic             o_gnt_v;
    logic [1:0]       o_gnt_id;
    logic [WIDTH-1:0] o_crd;
    logic             o_zero;
    logic             o_err;

    int n_comp = 0;
    int n_fail = 0;

    int m_crd;
    int m_ptr;
    bit m_err;

    base_crdarb #(.ways(WAYS), .width(WIDTH), .rstv(RSTV)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_v       (i_v),
        .o_r       (o_r),
        .i_crd_rtn (i_crd_rtn),
        .o_gnt_v   (o_gnt_v),
        .o_gnt_id  (o_gnt_id),
        .o_crd     (o_crd),
        .o_zero    (o_zero),
        .o_err     (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_comp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_crd = RSTV;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    // Apply one cycle of inputs, compare outputs with the model, then advance the model.
    task automatic step(input logic [WAYS-1:0] iv, input logic rtn);
        int  best;
        int  eid;
        bit  ev;
        bit  ep;
        int  d;
        @(negedge clk);
        i_v       = iv;
        i_crd_rtn = rtn;
        #1;
        best = WAYS;
        eid  = 0;
        ep   = 1'b0;
        for (int j = 0; j < WAYS; j++) begin
            if (iv[j]) begin
                d = (j - m_ptr + WAYS) % WAYS;
                if (d < best) begin
                    best = d;
                    eid  = j;
                end
            end
        end
        ev = (best < WAYS) && (m_crd > 0);
`ifdef BASE_CRDARB_PRIO0_EN
        if (iv[0] && m_crd > 0) begin
            eid = 0;
            ep  = 1'b1;
        end
`endif
        if (!ev) eid = 0;
        chk("o_r",      32'(o_r),      ev ? (32'd1 << eid) : 32'd0);
        chk("o_gnt_v",  32'(o_gnt_v),  32'(ev));
        chk("o_gnt_id", 32'(o_gnt_id), 32'(eid));
        chk("o_crd",    32'(o_crd),    32'(m_crd));
        chk("o_zero",   32'(o_zero),   32'(m_crd == 0));
        chk("o_err",    32'(o_err),    32'(m_err));
        if (rtn && !ev) begin
            if (m_crd == RSTV) m_err = 1'b1;
            else               m_crd = m_crd + 1;
        end else if (ev && !rtn) begin
            m_crd = m_crd - 1;
        end
        if (ev && !ep) m_ptr = (eid + 1) % WAYS;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_crd"},  32'(o_crd),    32'(RSTV));
        chk({tag, "_zero"}, 32'(o_zero),   32'd0);
        chk({tag, "_err"},  32'(o_err),    32'd0);
        chk({tag, "_r"},    32'(o_r),      32'd0);
        chk({tag, "_gv"},   32'(o_gnt_v),  32'd0);
        chk({tag, "_gid"},  32'(o_gnt_id), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        i_v       = 4'b1111;
        i_crd_rtn = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("in_reset");

        @(negedge clk);
        reset = 1'b1;
        i_v   = 4'b0000;
        #1;
        chk_reset_outputs("post_reset");

        // Four rotating grants drain 16 -> 12.
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 1'b0);
            chk("rr_order", 32'(o_gnt_id), 32'(k));
        end
        step(4'b0000, 1'b0);
        chk("crd_12", 32'(o_crd), 32'd12);

        // Drain the remaining credits, then starve and refill by one.
        for (int k = 0; k < 12; k++) step(4'b1111, 1'b0);
        step(4'b0010, 1'b0);
        chk("zero_flag", 32'(o_zero), 32'd1);
        chk("zero_nogr", 32'(o_r), 32'd0);
        step(4'b0010, 1'b1);
        chk("zero_rtn_nogr", 32'(o_r), 32'd0);
        step(4'b0010, 1'b0);
        chk("regrant_id", 32'(o_gnt_id), 32'd1);
        chk("regrant_v",  32'(o_gnt_v),  32'd1);
        step(4'b0000, 1'b0);
        chk("crd_back0", 32'(o_crd), 32'd0);

        // Simultaneous grant and return at five credits.
        for (int k = 0; k < 5; k++) step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        chk("both_gv", 32'(o_gnt_v), 32'd1);
        step(4'b0000, 1'b0);
        chk("crd_hold5", 32'(o_crd), 32'd5);

        // Put the pointer at 2 (grant requester 1), then request 0 and 2.
        step(4'b0010, 1'b0);
        step(4'b0101, 1'b0);
`ifdef BASE_CRDARB_PRIO0_EN
        chk("prio_id", 32'(o_gnt_id), 32'd0);
        step(4'b0100, 1'b0);
        chk("prio_ptr_kept", 32'(o_gnt_id), 32'd2);
`else
        chk("rr_id2", 32'(o_gnt_id), 32'd2);
`endif

        // Refill to full, then overflow.
        while (m_crd < RSTV) step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        chk("crd_full", 32'(o_crd), 32'(RSTV));
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        chk("ovf_crd", 32'(o_crd), 32'(RSTV));
        chk("ovf_err", 32'(o_err), 32'd1);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b0);
        chk("err_sticky", 32'(o_err), 32'd1);

        // Randomized traffic: drain-heavy, then return-heavy.
        for (int k = 0; k < 150; k++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        for (int k = 0; k < 150; k++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));

        // Asynchronous reset mid-operation.
        for (int k = 0; k < 6; k++) step(4'b1111, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        for (int k = 0; k < 60; k++)
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
        $finish;
    end

endmodule
